taylor_stage_2: RTL and testbench

TAYLOR_STAGE_2 -- requirements
Module: taylor_stage_2

---
 rtl/taylor_stage_2.sv | 94 +++++++++
 tb/tb_taylor_stage_2.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/taylor_stage_2.sv
// Final Horner stage of the e^r Taylor series: folds four coefficients into the
// partial sum from the previous stage, one multiply and one add per step.
//
// state  | meaning
// IDLE   | waiting for an operand pair, in_ready=1
// MUL    | acc <= acc*r (truncated to Q3.FRAC_W)
// ADD    | acc <= acc + c_k, advance k or finish
// DONE   | result on OUT, held until out_ready
module taylor_stage_2 #(
  parameter int FRAC_W = 23
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [FRAC_W+2:0]   IN_A,
  input  logic [FRAC_W+2:0]   IN_P,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [FRAC_W+2:0]   OUT
);

  localparam int W = FRAC_W + 3;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_ADD  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [W-1:0] C_ONE   = W'(1) << FRAC_W;
  localparam logic [W-1:0] C_HALF  = C_ONE >> 1;
  localparam logic [W-1:0] C_SIXTH = C_ONE / 6;

  logic [1:0]   state;
  logic [1:0]   k;
  logic [W-1:0] acc;
  logic [W-1:0] r;
  logic [W-1:0] mul_res;
  logic [W-1:0] coef;

  // Full-width product, drop FRAC_W fraction bits, keep the low W bits (wraps).
  assign mul_res = W'(({{W{1'b0}}, acc} * {{W{1'b0}}, r}) >> FRAC_W);

  always_comb begin
    coef = C_ONE;
    case (k)
      2'd0:    coef = C_SIXTH;
      2'd1:    coef = C_HALF;
      default: coef = C_ONE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= S_IDLE;
      k     <= 2'd0;
      acc   <= '0;
      r     <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            r     <= IN_A;
            acc   <= IN_P;
            k     <= 2'd0;
            state <= S_MUL;
          end
        end
        S_MUL: begin
          acc   <= mul_res;
          state <= S_ADD;
        end
        S_ADD: begin
          acc <= acc + coef;
          if (k == 2'd3) begin
            state <= S_DONE;
          end else begin
            k     <= k + 2'd1;
            state <= S_MUL;
          end
        end
        S_DONE: begin
          if (out_ready) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = (state == S_IDLE);
  assign out_valid = (state == S_DONE);
  assign OUT       = acc;

endmodule

// File: tb/tb_taylor_stage_2.sv
// Bench for taylor_stage_2: arithmetic reference model plus per-cycle compare,
// directed vectors with hand-computed results, back-pressure and reset cases.
module tb_taylor_stage_2;

  logic        CLK;
  logic        RST;
  logic        in_valid;
  logic        in_ready;
  logic [25:0] IN_A;
  logic [25:0] IN_P;
  logic        out_valid;
  logic        out_ready;
  logic [25:0] OUT;

  int checks = 0;
  int errors = 0;

  taylor_stage_2 #(.FRAC_W(23)) dut (
    .CLK(CLK), .RST(RST),
    .in_valid(in_valid), .in_ready(in_ready), .IN_A(IN_A), .IN_P(IN_P),
    .out_valid(out_valid), .out_ready(out_ready), .OUT(OUT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // e^r series by plain integer arithmetic: multiply, shift out 23 bits, wrap at 2^26.
  function automatic logic [25:0] ref_exp(input logic [25:0] r, input logic [25:0] p);
    longint unsigned a;
    longint unsigned c [4];
    c[0] = 64'h155555; c[1] = 64'h400000; c[2] = 64'h800000; c[3] = 64'h800000;
    a = p;
    for (int i = 0; i < 4; i++) begin
      a = ((a * longint'(r)) >> 23) % (64'd1 << 26);
      a = (a + c[i]) % (64'd1 << 26);
    end
    return a[25:0];
  endfunction

  // Transaction-level model: one operation in flight, result due 8 edges after acceptance.
  int          cyc = 0;
  int          acc_cyc = 0;
  bit          pending = 1'b0;
  logic [25:0] exp_out = '0;

  always @(posedge CLK) begin
    cyc++;
    if (RST) pending = 1'b0;
    else if (!pending && in_valid) begin
      pending = 1'b1;
      acc_cyc = cyc;
      exp_out = ref_exp(IN_A, IN_P);
    end else if (pending && (cyc - acc_cyc >= 9) && out_ready) pending = 1'b0;
  end

  always @(negedge CLK) begin
    if (RST) begin
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      chk("rst_out", 32'(OUT), 32'd0);
    end else begin
      chk("out_valid", 32'(out_valid), 32'(pending && (cyc - acc_cyc >= 8)));
      chk("in_ready", 32'(in_ready), 32'(!pending));
      if (pending && (cyc - acc_cyc >= 8)) chk("out_model", 32'(OUT), 32'(exp_out));
    end
  end

  task automatic txn(input logic [25:0] a, input logic [25:0] p, input logic [25:0] lit,
                     input bit use_lit, input int bp, input bit junk);
    int n;
    @(negedge CLK);
    in_valid = 1'b1; IN_A = a; IN_P = p; out_ready = (bp == 0);
    @(negedge CLK);
    if (junk) begin
      IN_A = 26'($urandom); IN_P = 26'($urandom);
    end else in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 20) begin
      @(negedge CLK);
      n++;
    end
    in_valid = 1'b0;
    if (!out_valid) begin
      chk("timeout", 32'(n), 32'd8);
      return;
    end
    chk("latency", 32'(n), 32'd8);
    if (use_lit) chk("out_literal", 32'(OUT), 32'(lit));
    if (bp > 0) begin
      repeat (bp) @(negedge CLK);
      chk("bp_valid_held", 32'(out_valid), 32'd1);
      if (use_lit) chk("bp_out_held", 32'(OUT), 32'(lit));
      out_ready = 1'b1;
    end
    @(negedge CLK);
    chk("release_in_ready", 32'(in_ready), 32'd1);
    chk("release_out_valid", 32'(out_valid), 32'd0);
  endtask

  initial begin
    RST = 1'b1; in_valid = 1'b0; out_ready = 1'b0; IN_A = '0; IN_P = '0;
    #1;
    chk("reset_out", 32'(OUT), 32'd0);
    chk("reset_in_ready", 32'(in_ready), 32'd1);
    repeat (3) @(negedge CLK);
    #2 RST = 1'b0;

    chk("model_zero", 32'(ref_exp(26'h0, 26'h2AAAAA)), 32'h800000);
    chk("model_unit", 32'(ref_exp(26'h800000, 26'h800000)), 32'h1D55555);
    chk("model_half", 32'(ref_exp(26'h400000, 26'h0)), 32'hD2AAAA);

    txn(26'h0, 26'h2AAAAA, 26'h800000, 1'b1, 0, 1'b0);
    txn(26'h800000, 26'h800000, 26'h1D55555, 1'b1, 0, 1'b1);
    txn(26'h400000, 26'h0, 26'hD2AAAA, 1'b1, 20, 1'b0);
    txn(26'h3FFFFFF, 26'h3FFFFFF, 26'h0, 1'b0, 3, 1'b1);

    // out_ready while idle must not disturb anything
    out_ready = 1'b1;
    repeat (3) @(negedge CLK);

    // abandon an operation mid-flight
    in_valid = 1'b1; IN_A = 26'h400000; IN_P = 26'h123456;
    @(negedge CLK);
    in_valid = 1'b0;
    repeat (4) @(negedge CLK);
    #2 RST = 1'b1;
    #1;
    chk("async_rst_out", 32'(OUT), 32'd0);
    chk("async_rst_in_ready", 32'(in_ready), 32'd1);
    chk("async_rst_out_valid", 32'(out_valid), 32'd0);
    @(negedge CLK);
    #2 RST = 1'b0;
    txn(26'h0, 26'h2AAAAA, 26'h800000, 1'b1, 0, 1'b0);

    for (int i = 0; i < 1500; i++) begin
      txn(26'($urandom_range(32'h7FFFFF, 0)), 26'($urandom_range(32'h1FFFFF, 0)),
          26'h0, 1'b0, (i % 5 == 0) ? int'($urandom_range(4, 1)) : 0, 1'($urandom));
    end

    repeat (2) @(negedge CLK);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
